// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap sequencer.
//   FP_ZERO / FP_ONE : IEEE-754 single-precision constants
//   state_t          : sequencer FSM states
//   clog2            : ceil(log2(value)), never less than 1, usable in constant expressions
package fir_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample history for the FIR sequencer.
//   clk, rst : clock and asynchronous active-high clear (every word -> +0.0)
//   we       : write strobe, stores wdata at waddr
//   raddr    : read index, rdata is the combinational read of that word
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int DW    = 32,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] words [NTAPS];

  // One register per word so the asynchronous clear maps onto plain flops.
  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_word
    logic [DW-1:0] word_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        word_reg <= FP_ZERO;
      end else if (we && (waddr == AW'(gi))) begin
        word_reg <= wdata;
      end
    end

    assign words[gi] = word_reg;
  end

  assign rdata = words[raddr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Drives a shared pipelined FP32 MAC through one NTAPS-tap FIR output per input sample.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   s_valid_i/s_data_i    : sample input, accepted only while idle (s_ready_o)
//   coef_we/addr/data_i   : coefficient writes, honoured only while idle; coef_err_o flags drops
//   dsp_x/h/fpopmode/ce_o : registered operand bus to the MAC, dsp_y_i is its result
//   m_valid/data_o,m_ready_i : result output with valid/ready handshake
//   busy_o                : high whenever a sample is in flight
// Operands are registered, so tap t appears on the DSP bus one cycle after the FSM
// visits it; the last tap is still on the bus in the first DRAIN cycle.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS   = 8,
  parameter int DSP_LAT = 4,
  parameter int DW      = 32,
  localparam int AW     = clog2(NTAPS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          s_valid_i,
  input  logic [DW-1:0] s_data_i,
  output logic          s_ready_o,
  input  logic          coef_we_i,
  input  logic [AW-1:0] coef_addr_i,
  input  logic [DW-1:0] coef_data_i,
  output logic          coef_err_o,
  output logic [DW-1:0] dsp_x_o,
  output logic [DW-1:0] dsp_h_o,
  output logic          dsp_fpopmode_o,
  output logic          dsp_ce_o,
  input  logic [DW-1:0] dsp_y_i,
  output logic          m_valid_o,
  output logic [DW-1:0] m_data_o,
  input  logic          m_ready_i,
  output logic          busy_o
);

  localparam int DCW = clog2(DSP_LAT + 2);

  state_t          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   tap;
  logic [DCW-1:0]  drain_cnt;
  logic [DW-1:0]   coef [NTAPS];
  logic [DW-1:0]   dline_rd;
  logic            accept;

  // Gated with reset so every output reads 0 while reset is held, and ready
  // rises as soon as reset is released.
  assign s_ready_o = (state == ST_IDLE) && !rst_i;
  assign busy_o    = (state != ST_IDLE);
  assign accept    = (state == ST_IDLE) && s_valid_i;

  fir_delay_line #(
    .NTAPS (NTAPS),
    .DW    (DW),
    .AW    (AW)
  ) u_dline (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (s_data_i),
    .raddr (wr_ptr - tap),  // newest sample first; wraps mod NTAPS
    .rdata (dline_rd)
  );

  // Coefficient bank; a write in the accept cycle lands before tap 0 reads it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef[i] <= FP_ZERO;
      end
    end else if (coef_we_i && (state == ST_IDLE)) begin
      coef[coef_addr_i] <= coef_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      wr_ptr         <= '0;
      tap            <= '0;
      drain_cnt      <= '0;
      dsp_x_o        <= FP_ZERO;
      dsp_h_o        <= FP_ZERO;
      dsp_fpopmode_o <= 1'b0;
      dsp_ce_o       <= 1'b0;
      m_valid_o      <= 1'b0;
      m_data_o       <= FP_ZERO;
      coef_err_o     <= 1'b0;
    end else begin
      coef_err_o     <= coef_we_i && (state != ST_IDLE);
      dsp_ce_o       <= 1'b0;
      dsp_fpopmode_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tap   <= '0;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          dsp_x_o        <= dline_rd;
          dsp_h_o        <= coef[tap];
          dsp_ce_o       <= 1'b1;
          dsp_fpopmode_o <= (tap != '0);  // tap 0 restarts the accumulator
          if (tap == AW'(NTAPS - 1)) begin
            wr_ptr    <= wr_ptr + 1'b1;
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        ST_DRAIN: begin
          // One extra cycle over DSP_LAT: the last tap only reaches the MAC
          // at the start of DRAIN because the operand bus is registered.
          if (drain_cnt == DCW'(DSP_LAT)) begin
            m_data_o  <= dsp_y_i;
            m_valid_o <= 1'b1;
            state     <= ST_OUT;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_OUT: begin
          if (m_ready_i) begin
            m_valid_o <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
`timescale 1ns/1ps
module tb_fir_tap_sequencer;

  localparam int NTAPS   = 8;
  localparam int DSP_LAT = 4;
  localparam int DW      = 32;
  localparam int LAT     = NTAPS + DSP_LAT + 1;  // accept edge -> m_valid_o high

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          s_valid_i = 1'b0;
  logic [DW-1:0] s_data_i = '0;
  logic          s_ready_o;
  logic          coef_we_i = 1'b0;
  logic [2:0]    coef_addr_i = '0;
  logic [DW-1:0] coef_data_i = '0;
  logic          coef_err_o;
  logic [DW-1:0] dsp_x_o;
  logic [DW-1:0] dsp_h_o;
  logic          dsp_fpopmode_o;
  logic          dsp_ce_o;
  logic [DW-1:0] dsp_y_i;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_ready_i = 1'b1;
  logic          busy_o;

  int total = 0;
  int bad   = 0;

  fir_tap_sequencer #(.NTAPS(NTAPS), .DSP_LAT(DSP_LAT), .DW(DW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .s_valid_i      (s_valid_i),
    .s_data_i       (s_data_i),
    .s_ready_o      (s_ready_o),
    .coef_we_i      (coef_we_i),
    .coef_addr_i    (coef_addr_i),
    .coef_data_i    (coef_data_i),
    .coef_err_o     (coef_err_o),
    .dsp_x_o        (dsp_x_o),
    .dsp_h_o        (dsp_h_o),
    .dsp_fpopmode_o (dsp_fpopmode_o),
    .dsp_ce_o       (dsp_ce_o),
    .dsp_y_i        (dsp_y_i),
    .m_valid_o      (m_valid_o),
    .m_data_o       (m_data_o),
    .m_ready_i      (m_ready_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // FP32 <-> real helpers (normal numbers and zero only; test values are small integers)
  function automatic real fp2real(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] real2fp(input real v);
    real         m;
    int          e;
    logic        s;
    logic [22:0] f;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = 23'(longint'((m - 1.0) * 8388608.0));
    return {s, 8'(e + 127), f};
  endfunction

  // Behavioural DSP: accumulator stage plus DSP_LAT-1 delay stages.
  real dsp_pipe [DSP_LAT];
  always @(posedge clk_i) begin
    if (dsp_ce_o) begin
      dsp_pipe[0] <= dsp_fpopmode_o ? dsp_pipe[0] + fp2real(dsp_x_o) * fp2real(dsp_h_o)
                                    : fp2real(dsp_x_o) * fp2real(dsp_h_o);
    end
    for (int i = 1; i < DSP_LAT; i++) dsp_pipe[i] <= dsp_pipe[i-1];
  end
  assign dsp_y_i = real2fp(dsp_pipe[DSP_LAT-1]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic write_coef(input int k, input logic [31:0] v);
    coef_we_i   = 1'b1;
    coef_addr_i = 3'(k);
    coef_data_i = v;
    @(negedge clk_i);
    coef_we_i   = 1'b0;
  endtask

  // mode 0: plain sample; 1: coef[0]=wdat written in the accept cycle;
  // 2: coef[0]=wdat attempted in the first ISSUE cycle (must be dropped).
  task automatic run_sample(input string tag, input logic [31:0] x, input logic [31:0] y_exp,
                            input int mode, input logic [31:0] wdat);
    int cnt;
    cnt = 0;
    while (!s_ready_o && cnt < 200) begin @(negedge clk_i); cnt++; end
    check1($sformatf("%s_rdy", tag), s_ready_o, 1'b1);
    s_valid_i = 1'b1;
    s_data_i  = x;
    if (mode == 1) begin coef_we_i = 1'b1; coef_addr_i = '0; coef_data_i = wdat; end
    @(posedge clk_i);
    @(negedge clk_i);
    s_valid_i = 1'b0;
    coef_we_i = 1'b0;
    cnt = 0;
    check1($sformatf("%s_busy", tag), busy_o, 1'b1);
    check1($sformatf("%s_nrdy", tag), s_ready_o, 1'b0);
    if (mode == 1) check1($sformatf("%s_noerr", tag), coef_err_o, 1'b0);
    if (mode == 2) begin
      coef_we_i = 1'b1; coef_addr_i = '0; coef_data_i = wdat;
      @(negedge clk_i); cnt++;
      coef_we_i = 1'b0;
      check1($sformatf("%s_err", tag), coef_err_o, 1'b1);
      @(negedge clk_i); cnt++;
      check1($sformatf("%s_err0", tag), coef_err_o, 1'b0);
    end
    while (!m_valid_o && cnt < 200) begin @(negedge clk_i); cnt++; end
    check($sformatf("%s_lat", tag), 32'(cnt), 32'(LAT));
    check($sformatf("%s_y", tag), m_data_o, y_exp);
    $display("sample %s: x=%h y=%h expect=%h lat=%0d", tag, x, m_data_o, y_exp, cnt);
    @(negedge clk_i);
    check1($sformatf("%s_hs", tag), m_valid_o, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] ramp [8];
    int cnt;
    int s;
    ramp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    // Reset state
    #1;
    check1("rst_valid", m_valid_o, 1'b0);
    check1("rst_busy", busy_o, 1'b0);
    check1("rst_rdy", s_ready_o, 1'b0);
    check1("rst_ce", dsp_ce_o, 1'b0);
    check1("rst_err", coef_err_o, 1'b0);
    check("rst_data", m_data_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check1("rst_rdy_after", s_ready_o, 1'b1);

    // 1: impulse through ramp coefficients
    @(negedge clk_i);
    for (int k = 0; k < NTAPS; k++) write_coef(k, ramp[k]);
    for (int n = 0; n < NTAPS; n++)
      run_sample($sformatf("t1_%0d", n), (n == 0) ? 32'h3F800000 : 32'h0, ramp[n], 0, 32'h0);

    // 2: single tap, coef[0]=5.0
    do_reset();
    write_coef(0, 32'h40A00000);
    run_sample("t2_a", 32'h40A00000, 32'h41C80000, 0, 32'h0);
    run_sample("t2_b", 32'h3F800000, 32'h40A00000, 0, 32'h0);

    // 3: back-pressure; coef[1]=1.0 so y = 5*x[n] + x[n-1]
    write_coef(1, 32'h3F800000);
    m_ready_i = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = 32'h40000000;
    @(posedge clk_i);
    @(negedge clk_i);
    s_data_i = 32'h40400000;  // keep offering a second sample while busy
    cnt = 0;
    while (!m_valid_o && cnt < 200) begin @(negedge clk_i); cnt++; end
    check("t3_lat", 32'(cnt), 32'(LAT));
    check("t3_y", m_data_o, 32'h41300000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      check1("t3_hold_v", m_valid_o, 1'b1);
      check("t3_hold_y", m_data_o, 32'h41300000);
      check1("t3_hold_rdy", s_ready_o, 1'b0);
    end
    $display("sample t3_bp: x=40000000 y=%h held 20 cycles", m_data_o);
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    @(negedge clk_i);
    check1("t3_hs", m_valid_o, 1'b0);
    check1("t3_idle", s_ready_o, 1'b1);
    run_sample("t3_next", 32'h3F800000, 32'h40E00000, 0, 32'h0);

    // 4: coefficient write while busy is dropped; in IDLE it applies immediately
    do_reset();
    write_coef(0, 32'h40A00000);
    run_sample("t4_busywr", 32'h40000000, 32'h41200000, 2, 32'h40E00000);
    run_sample("t4_after", 32'h40400000, 32'h41700000, 0, 32'h0);
    run_sample("t4_idlewr", 32'h3F800000, 32'h40E00000, 1, 32'h40E00000);

    // 5: moving sum over 2N+3 samples, x = 1,2,3,...
    do_reset();
    for (int k = 0; k < NTAPS; k++) write_coef(k, 32'h3F800000);
    for (int i = 1; i <= 2 * NTAPS + 3; i++) begin
      s = 0;
      for (int j = ((i - NTAPS + 1) > 1) ? (i - NTAPS + 1) : 1; j <= i; j++) s += j;
      run_sample($sformatf("t5_%0d", i), real2fp(real'(i)), real2fp(real'(s)), 0, 32'h0);
    end

    // 6: reset in the middle of ISSUE
    do_reset();
    for (int k = 0; k < NTAPS; k++) write_coef(k, ramp[k]);
    run_sample("t6_pre", 32'h40000000, 32'h40000000, 0, 32'h0);
    s_valid_i = 1'b1;
    s_data_i  = 32'h40400000;
    @(posedge clk_i);
    @(negedge clk_i);
    s_valid_i = 1'b0;
    @(negedge clk_i);
    check("t6_tap0_x", dsp_x_o, 32'h40400000);
    check("t6_tap0_h", dsp_h_o, ramp[0]);
    check1("t6_tap0_op", dsp_fpopmode_o, 1'b0);
    @(negedge clk_i);
    check("t6_tap1_x", dsp_x_o, 32'h40000000);
    check("t6_tap1_h", dsp_h_o, ramp[1]);
    check1("t6_tap1_op", dsp_fpopmode_o, 1'b1);
    @(negedge clk_i);
    check1("t6_ce_pre", dsp_ce_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check1("t6_valid", m_valid_o, 1'b0);
    check1("t6_busy", busy_o, 1'b0);
    check1("t6_ce", dsp_ce_o, 1'b0);
    check("t6_x", dsp_x_o, 32'h0);
    $display("reset t6: asserted during ISSUE");
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < NTAPS; k++) write_coef(k, ramp[k]);
    for (int n = 0; n < NTAPS; n++)
      run_sample($sformatf("t6_%0d", n), (n == 0) ? 32'h3F800000 : 32'h0, ramp[n], 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
